// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the high time and the period of an asynchronous PWM line in clk
// cycles. The input is synchronized, rising/falling edges are detected and a
// small IDLE/HIGH/LOW state machine counts cycles between them. A result is
// published once per full period (rise to rise). If no edge arrives within
// MAX_CNT cycles the block drops back to IDLE and flags a timeout together
// with the level the line is stuck at.
//
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a glitch filter
// between the synchronizer and the edge detector. The filtered level only
// follows the synchronized level after FILT_LEN consecutive identical
// samples, so shorter pulses are ignored and both edges are delayed by
// FILT_LEN cycles (high/period results are unaffected by that delay).
// Without the macro no filter logic is built.
//
// Parameters:
//   CNT_W     counter and result width
//   MAX_CNT   timeout count in clk cycles (must fit in CNT_W bits)
//   FILT_LEN  glitch filter stability length (filter build only)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   pwm_in       asynchronous PWM input
//   high_cnt     measured high time in clk cycles
//   period_cnt   measured period in clk cycles
//   meas_valid   one-cycle pulse, high_cnt/period_cnt just updated
//   timeout      no valid edge within MAX_CNT cycles; held until next result
//   stuck_level  synchronized pwm_in level captured when timeout was set
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W    = 14,
  parameter int MAX_CNT  = 16383,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // Reject configurations where the timeout count cannot be represented,
  // since the counter must never wrap.
  generate
    if (MAX_CNT < 1 || MAX_CNT > (2 ** CNT_W) - 1 || FILT_LEN < 1) begin : g_bad_params
      $error("pwm_capture: MAX_CNT must be 1..2^CNT_W-1 and FILT_LEN >= 1");
    end
  endgenerate

  // Synchronizer, previous-level flop and edge qualification
  logic s1;
  logic s2;
  logic s3;
  logic v1;
  logic v2;
  logic armed;
  logic lvl;
  logic rise;
  logic fall;

  // v1/v2 track which synchronizer stages hold real samples rather than
  // reset zeros. 'armed' is set only once a genuine low level has been seen,
  // so an input that is already high when reset is released does not look
  // like a rising edge; the block waits for the next true rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= lvl;
      v1 <= 1'b1;
      v2 <= v1;
      if (v2 && !s2 && !lvl) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);

  logic           filt;
  logic [FCW-1:0] filt_cnt;

  // filt_cnt counts consecutive samples that disagree with the filtered
  // level; any agreeing sample restarts the count, so a pulse shorter than
  // FILT_LEN never reaches the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (s2 == filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
      filt     <= s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign rise = lvl & ~s3 & armed;
  assign fall = ~lvl & s3;

  // Measurement state machine
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_tmp;
  logic [CNT_W-1:0] hi_tmp_nxt;
  logic [CNT_W-1:0] high_cnt_nxt;
  logic [CNT_W-1:0] period_cnt_nxt;
  logic             meas_valid_nxt;
  logic             timeout_nxt;
  logic             stuck_level_nxt;

  // Saturate rather than wrap: a fall landing exactly on MAX_CNT enters LOW
  // with the counter pinned, and LOW then times out on the next cycle.
  assign cnt_inc = (cnt == MAX_V) ? cnt : cnt + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_tmp      <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hi_tmp      <= hi_tmp_nxt;
      high_cnt    <= high_cnt_nxt;
      period_cnt  <= period_cnt_nxt;
      meas_valid  <= meas_valid_nxt;
      timeout     <= timeout_nxt;
      stuck_level <= stuck_level_nxt;
    end
  end

  // An edge always takes priority over the timeout check, so a period of
  // exactly MAX_CNT cycles still produces a valid result.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    hi_tmp_nxt      = hi_tmp;
    high_cnt_nxt    = high_cnt;
    period_cnt_nxt  = period_cnt;
    meas_valid_nxt  = 1'b0;
    timeout_nxt     = timeout;
    stuck_level_nxt = stuck_level;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          cnt_nxt   = ONE;
        end
      end

      HIGH: begin
        if (fall) begin
          state_nxt  = LOW;
          hi_tmp_nxt = cnt;
          cnt_nxt    = cnt_inc;
        end else if (cnt == MAX_V) begin
          state_nxt       = IDLE;
          cnt_nxt         = '0;
          timeout_nxt     = 1'b1;
          stuck_level_nxt = s2;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      LOW: begin
        if (rise) begin
          state_nxt      = HIGH;
          high_cnt_nxt   = hi_tmp;
          period_cnt_nxt = cnt;
          meas_valid_nxt = 1'b1;
          cnt_nxt        = ONE;
          timeout_nxt    = 1'b0;
        end else if (cnt == MAX_V) begin
          state_nxt       = IDLE;
          cnt_nxt         = '0;
          timeout_nxt     = 1'b1;
          stuck_level_nxt = s2;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed bench for pwm_capture. The PWM waveform is driven cycle by cycle
// on the falling clock edge. Whenever the stimulus is about to complete a
// full period, the expected high/period pair is pushed into a scoreboard
// queue; a monitor pops and compares it whenever meas_valid is seen. Other
// checks (reset values, timeout behaviour, held results) are made inline.
// Builds with or without PWM_CAPTURE_FILTER_EN; expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int CNT_W    = 14;
  localparam int MAX_CNT  = 16383;
  localparam int FILT_LEN = 4;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT    = FILT_LEN;
  localparam int B_HIGH = FILT_LEN;
  localparam int B_LOW  = FILT_LEN;
`else
  localparam int LAT    = 0;
  localparam int B_HIGH = 1;
  localparam int B_LOW  = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_level;

  typedef struct {
    int high;
    int period;
  } meas_t;

  meas_t sbq[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    measSeen   = 0;
  int    savedSeen;

  pwm_capture #(
    .CNT_W    (CNT_W),
    .MAX_CNT  (MAX_CNT),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    pwm_in = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expectMeas(input int h, input int p);
    meas_t m;
    m.high   = h;
    m.period = p;
    sbq.push_back(m);
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expectation.
  always @(posedge clk) begin
    meas_t e;
    #1;
    if (rst_n === 1'b1 && meas_valid === 1'b1) begin
      measSeen++;
      checkOutput("meas_expected", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checkOutput("meas_high_cnt", {18'd0, high_cnt}, e.high);
        checkOutput("meas_period_cnt", {18'd0, period_cnt}, e.period);
        checkOutput("meas_timeout_clr", {31'd0, timeout}, 32'd0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_high_cnt", {18'd0, high_cnt}, 0);
    checkOutput("rst_period_cnt", {18'd0, period_cnt}, 0);
    checkOutput("rst_meas_valid", {31'd0, meas_valid}, 0);
    checkOutput("rst_timeout", {31'd0, timeout}, 0);
    checkOutput("rst_stuck_level", {31'd0, stuck_level}, 0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 5);

    // 5500/11000, three periods
    $display("[TB] 5500/11000 waveform");
    applyStimulus(1'b1, 5500);
    applyStimulus(1'b0, 5500);
    checkOutput("A_no_meas_first_rise", measSeen, 0);
    expectMeas(5500, 11000);
    applyStimulus(1'b1, 5500);
    applyStimulus(1'b0, 5500);
    expectMeas(5500, 11000);
    applyStimulus(1'b1, 5500);
    applyStimulus(1'b0, 5500);
    checkOutput("A_meas_count", measSeen, 2);
    checkOutput("A_hold_high", {18'd0, high_cnt}, 5500);
    checkOutput("A_hold_period", {18'd0, period_cnt}, 11000);

    // Narrow pulses
    $display("[TB] narrow pulse waveform");
    expectMeas(5500, 11000);
    applyStimulus(1'b1, B_HIGH);
    applyStimulus(1'b0, B_LOW);
    for (int i = 0; i < 6; i++) begin
      expectMeas(B_HIGH, B_HIGH + B_LOW);
      applyStimulus(1'b1, B_HIGH);
      applyStimulus(1'b0, B_LOW);
    end
    checkOutput("B_meas_count", measSeen, 9);

    // Held high until timeout, then recovery
    $display("[TB] stuck-high timeout");
    expectMeas(B_HIGH, B_HIGH + B_LOW);
    applyStimulus(1'b1, 16385 + LAT);
    checkOutput("C_timeout_before_max", {31'd0, timeout}, 0);
    applyStimulus(1'b1, 1);
    checkOutput("C_timeout_set", {31'd0, timeout}, 1);
    checkOutput("C_stuck_level", {31'd0, stuck_level}, 1);
    checkOutput("C_high_unchanged", {18'd0, high_cnt}, B_HIGH);
    checkOutput("C_period_unchanged", {18'd0, period_cnt}, B_HIGH + B_LOW);
    applyStimulus(1'b1, 3000);
    checkOutput("C_timeout_held", {31'd0, timeout}, 1);
    applyStimulus(1'b0, 100);
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 50);
    checkOutput("C_timeout_after_idle_rise", {31'd0, timeout}, 1);
    expectMeas(50, 100);
    applyStimulus(1'b1, 100);
    checkOutput("C_timeout_cleared", {31'd0, timeout}, 0);

    // Period exactly MAX_CNT: the edge must win over the timeout
    $display("[TB] period equal to MAX_CNT");
    applyStimulus(1'b0, MAX_CNT - 100);
    expectMeas(100, MAX_CNT);
    applyStimulus(1'b1, 20);
    checkOutput("D_no_timeout", {31'd0, timeout}, 0);
    applyStimulus(1'b0, 20);

    // Reset in the middle of a high phase
    $display("[TB] reset mid-measurement");
    expectMeas(20, 40);
    applyStimulus(1'b1, 10);
    checkOutput("E_high_before_reset", {18'd0, high_cnt}, 20);
    rst_n = 1'b0;
    #1;
    checkOutput("E_rst_high_cnt", {18'd0, high_cnt}, 0);
    checkOutput("E_rst_period_cnt", {18'd0, period_cnt}, 0);
    checkOutput("E_rst_meas_valid", {31'd0, meas_valid}, 0);
    checkOutput("E_rst_timeout", {31'd0, timeout}, 0);
    checkOutput("E_rst_stuck_level", {31'd0, stuck_level}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    savedSeen = measSeen;
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 30);
    checkOutput("E_no_meas_first_rise", measSeen, savedSeen);
    checkOutput("E_high_still_zero", {18'd0, high_cnt}, 0);
    expectMeas(30, 60);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 30);
    checkOutput("E_meas_second_rise", measSeen, savedSeen + 1);

    // Two-cycle glitch inside a 5500/11000 period
    $display("[TB] glitch inside period");
    expectMeas(30, 60);
    applyStimulus(1'b1, 2000);
`ifndef PWM_CAPTURE_FILTER_EN
    expectMeas(2000, 2002);
`endif
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 3498);
    applyStimulus(1'b0, 5500);
`ifdef PWM_CAPTURE_FILTER_EN
    expectMeas(5500, 11000);
`else
    expectMeas(3498, 8998);
`endif
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 50);
`ifdef PWM_CAPTURE_FILTER_EN
    checkOutput("F_high_after_glitch", {18'd0, high_cnt}, 5500);
`else
    checkOutput("F_high_after_glitch", {18'd0, high_cnt}, 3498);
`endif

    for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
      @(negedge clk);
    end
    checkOutput("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
